// File: rtl/battleship_pkg.sv
`default_nettype none
// ============================================================================
// Module      : battleship_pkg
// Description : Shared Battleship types and constants. Holds the 2-bit cell
//               state encoding, the 24-bit RGB palette used by the board
//               renderer, and a helper function that maps a cell state to a
//               colour.
// Revision    : 1.0 - initial release
// ============================================================================
package battleship_pkg;

  typedef logic [1:0] cell_t;

  localparam cell_t AGUA        = 2'b00;
  localparam cell_t BARCO       = 2'b01;
  localparam cell_t ATACA_BARCO = 2'b10;
  localparam cell_t ATACA_AGUA  = 2'b11;

  localparam logic [23:0] c_RGB_BLACK  = 24'h000000;
  localparam logic [23:0] c_RGB_BG     = 24'h202020;
  localparam logic [23:0] c_RGB_WATER  = 24'h0040C0;
  localparam logic [23:0] c_RGB_SHIP   = 24'h808080;
  localparam logic [23:0] c_RGB_HIT    = 24'hFF0000;
  localparam logic [23:0] c_RGB_MISS   = 24'hFFFFFF;
  localparam logic [23:0] c_RGB_CURSOR = 24'hFFFF00;

  // i_hide_ship draws an intact ship as open water (opponent's board).
  function automatic logic [23:0] f_cell_rgb(input cell_t i_cell, input logic i_hide_ship);
    logic [23:0] w_rgb;
    w_rgb = c_RGB_WATER;
    case (i_cell)
      AGUA:        w_rgb = c_RGB_WATER;
      BARCO:       w_rgb = i_hide_ship ? c_RGB_WATER : c_RGB_SHIP;
      ATACA_BARCO: w_rgb = c_RGB_HIT;
      ATACA_AGUA:  w_rgb = c_RGB_MISS;
    endcase
    return w_rgb;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cell_locator.sv
`default_nettype none
// ============================================================================
// Module      : cell_locator
// Description : One-axis board locator. On an enabled load it starts a
//               5-cell span at sub=0/idx=0; afterwards each enable advances
//               sub, wrapping at CELL_SIZE-1 into the next idx. The span ends
//               (in_range drops) after the last pixel of cell 4.
// Ports       : clk, rst (async, active-low)
//               i_en       - advance/load qualifier
//               i_load     - start a new span (wins over advance)
//               i_clr      - force in_range low (wins over load)
//               o_sub      - offset inside the current cell
//               o_idx      - cell index 0..4
//               o_in_range - 1 while inside the 5-cell span
// Revision    : 1.0 - initial release
// ============================================================================
module cell_locator #(
  parameter int CELL_SIZE = 40,
  parameter int SUB_W     = $clog2(CELL_SIZE)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_load,
  input  logic             i_clr,
  output logic [SUB_W-1:0] o_sub,
  output logic [2:0]       o_idx,
  output logic             o_in_range
);

  localparam logic [SUB_W-1:0] c_SUB_LAST = SUB_W'(CELL_SIZE - 1);
  localparam logic [2:0]       c_IDX_LAST = 3'd4;

  logic [SUB_W-1:0] r_sub;
  logic [2:0]       r_idx;
  logic             r_in_range;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sub      <= '0;
      r_idx      <= '0;
      r_in_range <= 1'b0;
    end else if (i_en) begin
      if (i_load) begin
        r_sub      <= '0;
        r_idx      <= '0;
        r_in_range <= 1'b1;
      end else if (r_in_range) begin
        if (r_sub == c_SUB_LAST) begin
          r_sub <= '0;
          if (r_idx == c_IDX_LAST) begin
            // Past the last cell: park the index so it never exceeds 4.
            r_idx      <= '0;
            r_in_range <= 1'b0;
          end else begin
            r_idx <= r_idx + 3'd1;
          end
        end else begin
          r_sub <= r_sub + 1'b1;
        end
      end
      if (i_clr) begin
        r_in_range <= 1'b0;
      end
    end
  end

  assign o_sub      = r_sub;
  assign o_idx      = r_idx;
  assign o_in_range = r_in_range;

endmodule
`default_nettype wire

// File: rtl/board_renderer.sv
`default_nettype none
// ============================================================================
// Module      : board_renderer
// Description : Pixel stage for the Battleship board. Two pix_en-qualified
//               pipeline stages: stage 1 locates the pixel on the player or
//               PC board (cell row/col and in-cell offset) and delays the
//               timing signals; stage 2 picks the colour (grid, cursor, cell
//               state) and delays the syncs once more, giving a 2-tick
//               latency on both RGB and sync.
// Ports       : clk, rst (async, active-low), pix_en
//               x, y, video_on, hsync_i, vsync_i  - sync generator timing
//               tablero_jugador, tablero_pc       - 5x5 cell states [row][col]
//               i_actual, j_actual, cursor_on_pc  - cursor row/col/board
//               red, green, blue                  - pixel colour
//               hsync_o, vsync_o                  - syncs aligned to colour
// Options     : BOARD_RENDERER_REVEAL_PC_EN - show PC ships in gray.
// Revision    : 1.0 - initial release
// ============================================================================
module board_renderer
  import battleship_pkg::*;
#(
  parameter int CELL_SIZE = 40,
  parameter int GRID_W    = 2,
  parameter int P_X0      = 40,
  parameter int PC_X0     = 400,
  parameter int BOARD_Y0  = 140
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pix_en,
  input  logic [9:0]           x,
  input  logic [9:0]           y,
  input  logic                 video_on,
  input  logic                 hsync_i,
  input  logic                 vsync_i,
  input  cell_t [4:0][4:0]     tablero_jugador,
  input  cell_t [4:0][4:0]     tablero_pc,
  input  logic [2:0]           i_actual,
  input  logic [2:0]           j_actual,
  input  logic                 cursor_on_pc,
  output logic [7:0]           red,
  output logic [7:0]           green,
  output logic [7:0]           blue,
  output logic                 hsync_o,
  output logic                 vsync_o
);

  localparam int                 c_SUB_W    = $clog2(CELL_SIZE);
  localparam logic [9:0]         c_P_X0     = 10'(P_X0);
  localparam logic [9:0]         c_PC_X0    = 10'(PC_X0);
  localparam logic [9:0]         c_BOARD_Y0 = 10'(BOARD_Y0);
  localparam logic [c_SUB_W-1:0] c_GRID     = c_SUB_W'(GRID_W);
  // Cursor frame occupies the right/bottom band of the cell.
  localparam logic [c_SUB_W-1:0] c_CUR_EDGE = c_SUB_W'(CELL_SIZE - GRID_W - 2);

`ifdef BOARD_RENDERER_REVEAL_PC_EN
  localparam logic c_HIDE_PC_SHIPS = 1'b0;
`else
  localparam logic c_HIDE_PC_SHIPS = 1'b1;
`endif

  if ((P_X0 + 5 * CELL_SIZE > PC_X0) || (PC_X0 + 5 * CELL_SIZE > 640)) begin : g_cfg_check
    $error("board_renderer: boards overlap or exceed the 640-pixel active width");
  end

  // --------------------------------------------------------------------------
  // Stage 1: locators and timing delay
  // --------------------------------------------------------------------------
  logic               w_x_load_player;
  logic               w_x_load_pc;
  logic               w_y_en;
  logic [c_SUB_W-1:0] w_subx;
  logic [c_SUB_W-1:0] w_suby;
  logic [2:0]         w_col;
  logic [2:0]         w_row;
  logic               w_in_x;
  logic               w_in_y;

  assign w_x_load_player = (x == c_P_X0);
  assign w_x_load_pc     = (x == c_PC_X0);
  // Vertical state moves once per line so it is stable across the line.
  assign w_y_en          = pix_en && (x == 10'd0);

  cell_locator #(
    .CELL_SIZE (CELL_SIZE),
    .SUB_W     (c_SUB_W)
  ) u_loc_x (
    .clk        (clk),
    .rst        (rst),
    .i_en       (pix_en),
    .i_load     (w_x_load_player || w_x_load_pc),
    .i_clr      (1'b0),
    .o_sub      (w_subx),
    .o_idx      (w_col),
    .o_in_range (w_in_x)
  );

  cell_locator #(
    .CELL_SIZE (CELL_SIZE),
    .SUB_W     (c_SUB_W)
  ) u_loc_y (
    .clk        (clk),
    .rst        (rst),
    .i_en       (w_y_en),
    .i_load     (y == c_BOARD_Y0),
    .i_clr      (y == 10'd0),
    .o_sub      (w_suby),
    .o_idx      (w_row),
    .o_in_range (w_in_y)
  );

  logic r_sel_pc;
  logic r_video_d;
  logic r_hsync_d;
  logic r_vsync_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sel_pc  <= 1'b0;
      r_video_d <= 1'b0;
      r_hsync_d <= 1'b0;
      r_vsync_d <= 1'b0;
    end else if (pix_en) begin
      if (w_x_load_player) begin
        r_sel_pc <= 1'b0;
      end else if (w_x_load_pc) begin
        r_sel_pc <= 1'b1;
      end
      r_video_d <= video_on;
      r_hsync_d <= hsync_i;
      r_vsync_d <= vsync_i;
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2: colour selection (board contents sampled live here)
  // --------------------------------------------------------------------------
  cell_t       w_cell;
  logic        w_cursor_cell;
  logic [23:0] w_rgb;

  always_comb begin
    w_cell        = r_sel_pc ? tablero_pc[w_row][w_col] : tablero_jugador[w_row][w_col];
    w_cursor_cell = (w_row == i_actual) && (w_col == j_actual) && (r_sel_pc == cursor_on_pc);
    w_rgb         = c_RGB_BLACK;
    if (!r_video_d) begin
      w_rgb = c_RGB_BLACK;
    end else if (!(w_in_x && w_in_y)) begin
      w_rgb = c_RGB_BG;
    end else if ((w_subx < c_GRID) || (w_suby < c_GRID)) begin
      w_rgb = c_RGB_BLACK;
    end else if (w_cursor_cell && ((w_subx >= c_CUR_EDGE) || (w_suby >= c_CUR_EDGE))) begin
      w_rgb = c_RGB_CURSOR;
    end else begin
      w_rgb = f_cell_rgb(w_cell, r_sel_pc && c_HIDE_PC_SHIPS);
    end
  end

  logic [23:0] r_rgb;
  logic        r_hsync_q;
  logic        r_vsync_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rgb     <= c_RGB_BLACK;
      r_hsync_q <= 1'b1;
      r_vsync_q <= 1'b1;
    end else if (pix_en) begin
      r_rgb     <= w_rgb;
      r_hsync_q <= r_hsync_d;
      r_vsync_q <= r_vsync_d;
    end
  end

  assign red     = r_rgb[23:16];
  assign green   = r_rgb[15:8];
  assign blue    = r_rgb[7:0];
  assign hsync_o = r_hsync_q;
  assign vsync_o = r_vsync_q;

endmodule
`default_nettype wire

// File: tb/tb_board_renderer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_board_renderer
// Description : Self-checking bench for board_renderer. Drives compressed
//               frames (every line gets its x=0 tick; selected lines are swept
//               pixel by pixel) and compares every output against a geometric
//               reference model plus a table of fixed expected pixels.
// Options     : BOARD_RENDERER_REVEAL_PC_EN changes PC ship expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_board_renderer;
  import battleship_pkg::*;

`ifdef BOARD_RENDERER_REVEAL_PC_EN
  localparam bit REVEAL = 1'b1;
`else
  localparam bit REVEAL = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             pix_en;
  logic [9:0]       x;
  logic [9:0]       y;
  logic             video_on;
  logic             hsync_i;
  logic             vsync_i;
  cell_t [4:0][4:0] brd_jug;
  cell_t [4:0][4:0] brd_pc;
  logic [2:0]       cur_i;
  logic [2:0]       cur_j;
  logic             cur_pc;
  logic [7:0]       red;
  logic [7:0]       green;
  logic [7:0]       blue;
  logic             hsync_o;
  logic             vsync_o;

  board_renderer dut (
    .clk             (clk),
    .rst             (rst),
    .pix_en          (pix_en),
    .x               (x),
    .y               (y),
    .video_on        (video_on),
    .hsync_i         (hsync_i),
    .vsync_i         (vsync_i),
    .tablero_jugador (brd_jug),
    .tablero_pc      (brd_pc),
    .i_actual        (cur_i),
    .j_actual        (cur_j),
    .cursor_on_pc    (cur_pc),
    .red             (red),
    .green           (green),
    .blue            (blue),
    .hsync_o         (hsync_o),
    .vsync_o         (vsync_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  bit alt_mode;
  // Model: pixel held in the first stage, and the expected outputs.
  int          m_s1_x, m_s1_y;
  bit          m_s1_vid, m_s1_hs, m_s1_vs;
  int          m_out_x, m_out_y;
  logic [23:0] m_rgb;
  bit          m_hs, m_vs;

  int          full_lines[$];
  int          dir_x[$];
  int          dir_y[$];
  logic [23:0] dir_c[$];
  int          dir_hits;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] ref_rgb(input int px, input int py, input bit vid);
    int    ox, oy, r, c;
    bit    pc;
    cell_t st;
    if (!vid) return 24'h000000;
    if (px >= 40 && px < 240) begin
      pc = 1'b0; ox = px - 40;
    end else if (px >= 400 && px < 600) begin
      pc = 1'b1; ox = px - 400;
    end else begin
      return 24'h202020;
    end
    if (py < 140 || py >= 340) return 24'h202020;
    oy = py - 140;
    if ((ox % 40) < 2 || (oy % 40) < 2) return 24'h000000;
    r = oy / 40;
    c = ox / 40;
    if (r == int'(cur_i) && c == int'(cur_j) && pc == cur_pc &&
        ((ox % 40) >= 36 || (oy % 40) >= 36)) return 24'hFFFF00;
    st = pc ? brd_pc[r][c] : brd_jug[r][c];
    case (st)
      2'b00:   return 24'h0040C0;
      2'b01:   return (pc && !REVEAL) ? 24'h0040C0 : 24'h808080;
      2'b10:   return 24'hFF0000;
      default: return 24'hFFFFFF;
    endcase
  endfunction

  task automatic model_reset();
    m_s1_x = -1; m_s1_y = -1;
    m_s1_vid = 1'b0; m_s1_hs = 1'b0; m_s1_vs = 1'b0;
    m_out_x = -1; m_out_y = -1;
    m_rgb = 24'h0; m_hs = 1'b1; m_vs = 1'b1;
  endtask

  task automatic check_outs(input string tag);
    chk({tag, "_rgb"}, {red, green, blue}, m_rgb);
    chk({tag, "_hs"}, hsync_o, m_hs);
    chk({tag, "_vs"}, vsync_o, m_vs);
  endtask

  task automatic tick(input int px, input int py, input bit vid, input bit hs, input bit vs);
    int idle;
    idle = alt_mode ? 1 : (($urandom_range(0, 2) == 0) ? 1 : 0);
    for (int k = 0; k < idle; k++) begin
      pix_en = 1'b0;
      @(posedge clk); #1;
      check_outs("hold");
    end
    x = 10'(px); y = 10'(py); video_on = vid; hsync_i = hs; vsync_i = vs;
    pix_en = 1'b1;
    @(posedge clk); #1;
    m_out_x = m_s1_x; m_out_y = m_s1_y;
    m_rgb = ref_rgb(m_s1_x, m_s1_y, m_s1_vid);
    m_hs = m_s1_hs; m_vs = m_s1_vs;
    m_s1_x = px; m_s1_y = py; m_s1_vid = vid; m_s1_hs = hs; m_s1_vs = vs;
    pix_en = 1'b0;
    check_outs("pix");
    for (int k = 0; k < dir_x.size(); k++) begin
      if (m_out_x == dir_x[k] && m_out_y == dir_y[k]) begin
        chk($sformatf("dir(%0d,%0d)", dir_x[k], dir_y[k]), {red, green, blue}, dir_c[k]);
        dir_hits++;
      end
    end
  endtask

  task automatic add_dir(input int px, input int py, input logic [23:0] c);
    dir_x.push_back(px); dir_y.push_back(py); dir_c.push_back(c);
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    #1;
    chk("arst_rgb", {red, green, blue}, 24'h0);
    chk("arst_hs", hsync_o, 1'b1);
    chk("arst_vs", vsync_o, 1'b1);
    pix_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("arst_hold_rgb", {red, green, blue}, 24'h0);
    pix_en = 1'b0;
    rst = 1'b1;
    model_reset();
  endtask

  function automatic bit is_full(input int ln);
    foreach (full_lines[k]) if (full_lines[k] == ln) return 1'b1;
    return 1'b0;
  endfunction

  task automatic randomize_inputs();
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) begin
        brd_jug[r][c] = 2'($urandom);
        brd_pc[r][c]  = 2'($urandom);
      end
    cur_i  = 3'($urandom_range(0, 5));
    cur_j  = 3'($urandom_range(0, 5));
    cur_pc = 1'($urandom);
  endtask

  task automatic frame(input bit directed, input int short_ln, input int abort_ln);
    bit vid, hs, vs;
    for (int ln = 0; ln < 525; ln++) begin
      vs = !(ln >= 490 && ln < 492);
      if (is_full(ln) || ln == short_ln || ln == abort_ln) begin
        for (int px = 0; px < 660; px++) begin
          if (ln == short_ln && px > 30) break;
          if (ln == abort_ln && px > 300) begin
            apply_reset();
            return;
          end
          if (!directed && $urandom_range(0, 199) == 0) begin
            brd_pc[$urandom_range(0, 4)][$urandom_range(0, 4)]  = 2'($urandom);
            brd_jug[$urandom_range(0, 4)][$urandom_range(0, 4)] = 2'($urandom);
            if ($urandom_range(0, 3) == 0) cur_pc = ~cur_pc;
          end
          vid = (px < 640) && (ln < 480) && (directed || $urandom_range(0, 15) != 0);
          hs  = directed ? (px < 650) : ($urandom_range(0, 3) != 0);
          tick(px, ln, vid, hs, directed ? vs : 1'($urandom));
        end
      end else begin
        tick(0, ln, ln < 480, 1'b1, vs);
      end
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; pix_en = 1'b0; x = '0; y = '0;
    video_on = 1'b0; hsync_i = 1'b1; vsync_i = 1'b1;
    brd_jug = '0; brd_pc = '0; cur_i = '0; cur_j = '0; cur_pc = 1'b0;
    alt_mode = 1'b0;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      pix_en = 1'(k);
      @(posedge clk); #1;
      chk("rst_rgb", {red, green, blue}, 24'h0);
      chk("rst_hs", hsync_o, 1'b1);
      chk("rst_vs", vsync_o, 1'b1);
    end
    pix_en = 1'b0;
    rst = 1'b1;

    // Frame A: all water, cursor (0,0) on player board, pix_en every other clock.
    alt_mode = 1'b1;
    full_lines = '{141, 160, 177, 200};
    dir_hits = 0;
    add_dir(60, 160, 24'h0040C0);
    add_dir(40, 160, 24'h000000);
    add_dir(60, 141, 24'h000000);
    add_dir(77, 160, 24'hFFFF00);
    add_dir(60, 177, 24'hFFFF00);
    add_dir(240, 160, 24'h202020);
    add_dir(300, 200, 24'h202020);
    frame(1'b1, -1, -1);
    chk("dirA_hits", dir_hits, dir_x.size());

    // Frame B: ships, hits and misses; cursor (1,1) on PC board.
    alt_mode = 1'b0;
    dir_x.delete(); dir_y.delete(); dir_c.delete();
    dir_hits = 0;
    brd_jug[2][3] = BARCO;
    brd_pc[2][3]  = BARCO;
    brd_pc[4][4]  = ATACA_BARCO;
    brd_pc[0][0]  = ATACA_AGUA;
    cur_i = 3'd1; cur_j = 3'd1; cur_pc = 1'b1;
    full_lines = '{160, 200, 240, 320, 339, 340};
    add_dir(180, 240, 24'h808080);
    add_dir(540, 240, REVEAL ? 24'h808080 : 24'h0040C0);
    add_dir(580, 320, 24'hFF0000);
    add_dir(420, 160, 24'hFFFFFF);
    add_dir(478, 200, 24'hFFFF00);
    add_dir(118, 200, 24'h0040C0);
    add_dir(300, 200, 24'h202020);
    add_dir(600, 240, 24'h202020);
    add_dir(60, 339, 24'h0040C0);
    add_dir(60, 340, 24'h202020);
    frame(1'b1, -1, -1);
    chk("dirB_hits", dir_hits, dir_x.size());
    dir_x.delete(); dir_y.delete(); dir_c.delete();

    // Mid-frame reset, then a fresh frame.
    randomize_inputs();
    full_lines = '{150};
    frame(1'b0, -1, 200);

    // Randomized frames.
    for (int f = 0; f < 4; f++) begin
      randomize_inputs();
      full_lines = '{};
      for (int k = 0; k < 4; k++) full_lines.push_back($urandom_range(130, 345));
      frame(1'b0, $urandom_range(140, 339), -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
